// File: rtl/screen_select.sv
// Final screen arbiter: top-level MENU/GAME/ERROR state, frame-aligned source switching,
// error auto-return timeout and registered, blank-forced VGA output.
package screen_select_pkg;
  localparam int unsigned HC_W  = 11;
  localparam int unsigned VC_W  = 11;
  localparam int unsigned RGB_W = 12;

  typedef struct packed {
    logic [HC_W-1:0] hcount;
    logic [VC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
  } vga_t;
endpackage

module screen_select
  import screen_select_pkg::*;
#(
  parameter int unsigned ERR_TIMEOUT_FRAMES = 600,
  parameter int unsigned TMO_W              = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  vga_t             vga_menu,
  input  logic [RGB_W-1:0] rgb_menu,
  input  vga_t             vga_game,
  input  logic [RGB_W-1:0] rgb_game,
  input  vga_t             vga_err,
  input  logic [RGB_W-1:0] rgb_err,
  input  logic             start_req,
  input  logic             end_req,
  input  logic             err_req,
  input  logic             back_req,
  output vga_t             vga_out,
  output logic [RGB_W-1:0] rgb_o,
  output logic [1:0]       screen_o,
  output logic             frame_tick
);

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    GAME  = 2'd1,
    ERROR = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_START = 3'd1,
    REQ_END   = 3'd2,
    REQ_BACK  = 3'd3,
    REQ_ERR   = 3'd4
  } req_t;

  localparam bit               TMO_EN   = (ERR_TIMEOUT_FRAMES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ERR_TIMEOUT_FRAMES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  state_t           state;
  req_t             pending;
  logic [TMO_W-1:0] tmo_cnt;
  logic             vblnk_d;

  vga_t             sel;
  logic [RGB_W-1:0] sel_rgb;
  req_t             new_req;
  req_t             eff_req;
  logic             boundary;
  logic             tmo_hit;

  function automatic logic [1:0] req_prio(input req_t r);
    case (r)
      REQ_ERR:            return 2'd3;
      REQ_BACK, REQ_END:  return 2'd2;
      REQ_START:          return 2'd1;
      default:            return 2'd0;
    endcase
  endfunction

  // Source mux driven by the current screen
  always_comb begin
    sel     = vga_menu;
    sel_rgb = rgb_menu;
    case (state)
      GAME: begin
        sel     = vga_game;
        sel_rgb = rgb_game;
      end
      ERROR: begin
        sel     = vga_err;
        sel_rgb = rgb_err;
      end
      default: begin
        sel     = vga_menu;
        sel_rgb = rgb_menu;
      end
    endcase
  end

  // Highest-priority request of this cycle, merged with the latched one
  always_comb begin
    new_req = REQ_NONE;
    if (err_req)        new_req = REQ_ERR;
    else if (back_req)  new_req = REQ_BACK;
    else if (end_req)   new_req = REQ_END;
    else if (start_req) new_req = REQ_START;

    eff_req = (req_prio(new_req) >= req_prio(pending)) ? new_req : pending;
  end

  assign boundary = sel.vblnk & ~vblnk_d;
  assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);
  assign screen_o = state;

  // Screen FSM, request latch, timeout counter and registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MENU;
      pending    <= REQ_NONE;
      tmo_cnt    <= '0;
      vblnk_d    <= 1'b1;
      vga_out    <= '0;
      rgb_o      <= '0;
      frame_tick <= 1'b0;
    end else begin
      vga_out    <= sel;
      rgb_o      <= (sel.hblnk | sel.vblnk) ? '0 : sel_rgb;
      vblnk_d    <= sel.vblnk;
      frame_tick <= boundary;

      if (boundary) begin
        pending <= REQ_NONE;
        if (eff_req == REQ_ERR) begin
          state   <= ERROR;
          tmo_cnt <= '0;
        end else begin
          case (state)
            MENU: if (eff_req == REQ_START) state <= GAME;
            GAME: if (eff_req == REQ_END)   state <= MENU;
            ERROR: begin
              if (eff_req == REQ_BACK || tmo_hit) begin
                state <= MENU;
              end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
              end
            end
            default: state <= MENU;
          endcase
        end
      end else begin
        pending <= eff_req;
      end
    end
  end

endmodule
